regfile_mp_sb: RTL and testbench

Parametrised successor to the 32x64 datapath register file. It adds:
- configurable width, depth and read-port count;
- a second write port for late load writeback;
- write-to-read forwarding on both write ports;
- a configurable hardwired-zero register;
- a synchronous-reset init sequencer that loads registers one per cycle;
- a pending-write scoreboard that drives per-read-port busy flags.

It sits in the decode stage and feeds operand reads and the hazard unit.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_mp_sb_scoreboard.sv | 43 ++++
 rtl/regfile_mp_sb.sv | 95 +++++++++
 tb/tb_regfile_mp_sb.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and init-value helper for the multi-port register file.
package regfile_pkg;
  typedef enum logic {RF_INIT, RF_RUN} rf_state_t;

  localparam int RF_MAXW = 256;

  // Init value for register idx; callers truncate to their data width.
  function automatic logic [RF_MAXW-1:0] rf_init_val(input int idx, input int init_idx,
                                                     input int zero_reg);
    logic [RF_MAXW-1:0] v;
    v = '0;
    if (init_idx != 0 && idx != zero_reg) v[31:0] = idx;
    return v;
  endfunction
endpackage

// File: rtl/regfile_mp_sb_scoreboard.sv
// Pending-load scoreboard: one bit per register, set on issue, cleared on load writeback.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int AW       = $clog2(NREG),
  parameter int NRD      = 2,
  parameter int ZERO_REG = NREG-1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            iss_v,
  input  logic [AW-1:0]   iss_rd,
  input  logic            we_b,
  input  logic [AW-1:0]   wa_b,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD-1:0]  busy
);
  localparam logic [AW:0] ZR = (AW+1)'(ZERO_REG);

  logic [NREG-1:0] pend_q, pend_d;

  always_comb begin
    pend_d = pend_q;
    if (run) begin
      // Clear first so a same-cycle re-issue keeps the bit set.
      if (we_b) pend_d[wa_b] = 1'b0;
      if (iss_v && ({1'b0, iss_rd} != ZR)) pend_d[iss_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_busy
    logic [AW-1:0] a;
    assign a       = ra[i*AW +: AW];
    assign busy[i] = run & pend_q[a] & ~(we_b && (wa_b == a)) & ({1'b0, a} != ZR);
  end
endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with dual write ports, forwarding, zero register,
// init sequencer and pending-load busy flags.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int N        = 64,
  parameter int NREG     = 32,
  parameter int AW       = $clog2(NREG),
  parameter int NRD      = 2,
  parameter int ZERO_REG = NREG-1,
  parameter int INIT_IDX = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD*N-1:0]  rd,
  output logic [NRD-1:0]    busy,
  input  logic              we_a,
  input  logic [AW-1:0]     wa_a,
  input  logic [N-1:0]      wd_a,
  input  logic              we_b,
  input  logic [AW-1:0]     wa_b,
  input  logic [N-1:0]      wd_b,
  input  logic              iss_v,
  input  logic [AW-1:0]     iss_rd,
  output logic              rdy
);
  localparam logic [AW:0] ZR       = (AW+1)'(ZERO_REG);
  localparam logic [AW:0] PTR_LAST = (AW+1)'(NREG-1);

  rf_state_t state_q, state_d;
  logic [AW:0] ptr_q, ptr_d;
  logic [NREG-1:0][N-1:0] mem_q, mem_d;
  logic [RF_MAXW-1:0] init_full;
  logic run;

  assign run       = (state_q == RF_RUN);
  assign rdy       = run;
  assign init_full = rf_init_val(32'(ptr_q), INIT_IDX, ZERO_REG);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    mem_d   = mem_q;
    if (state_q == RF_INIT) begin
      mem_d[ptr_q[AW-1:0]] = init_full[N-1:0];
      ptr_d                = ptr_q + 1'b1;
      if (ptr_q == PTR_LAST) state_d = RF_RUN;
    end else begin
      // B applied last so it wins an address collision.
      if (we_a && ({1'b0, wa_a} != ZR)) mem_d[wa_a] = wd_a;
      if (we_b && ({1'b0, wa_b} != ZR)) mem_d[wa_b] = wd_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RF_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Contents are undefined until the init sequence overwrites them.
  always_ff @(posedge clk) mem_q <= mem_d;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic [N-1:0]  rd_i;
    assign a = ra[i*AW +: AW];
    always_comb begin
      rd_i = '0;
      if (run && ({1'b0, a} != ZR)) begin
        if (we_b && (wa_b == a))      rd_i = wd_b;
        else if (we_a && (wa_a == a)) rd_i = wd_a;
        else                          rd_i = mem_q[a];
      end
    end
    assign rd[i*N +: N] = rd_i;
  end

  rf_scoreboard #(.NREG(NREG), .AW(AW), .NRD(NRD), .ZERO_REG(ZERO_REG)) u_sb (
    .clk    (clk),
    .reset  (reset),
    .run    (run),
    .iss_v  (iss_v),
    .iss_rd (iss_rd),
    .we_b   (we_b),
    .wa_b   (wa_b),
    .ra     (ra),
    .busy   (busy)
  );
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Randomized scoreboard bench for regfile_mp_sb against an array-based reference model.
module tb_regfile_mp_sb;
  localparam int N = 64, NREG = 32, AW = 5, NRD = 2, ZR = 31;

  logic clk = 0;
  always #5 clk = ~clk;

  logic reset;
  logic [NRD*AW-1:0] ra;
  logic [NRD*N-1:0]  rd;
  logic [NRD-1:0]    busy;
  logic we_a, we_b, iss_v, rdy;
  logic [AW-1:0] wa_a, wa_b, iss_rd;
  logic [N-1:0]  wd_a, wd_b;

  regfile_mp_sb dut (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd), .busy(busy),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .iss_v(iss_v), .iss_rd(iss_rd), .rdy(rdy)
  );

  typedef struct {
    int            cyc;
    logic [N-1:0]  rd [NRD];
    logic [NRD-1:0] busy;
    logic          rdy;
  } exp_t;

  exp_t exp_q[$];
  int tests = 0, fails = 0, cyc = 0;

  // Reference model state
  logic [N-1:0] m_reg [NREG];
  bit           m_pend [NREG];
  int           m_init_left;  // cycles of init still to run; 0 => running
  bit           m_valid = 0;

  function automatic logic [N-1:0] init_v(int i);
    return (i == ZR) ? '0 : N'(i);
  endfunction

  task automatic cycle(input bit rst, input bit wea, input int waa, input logic [N-1:0] wda,
                       input bit web, input int wab, input logic [N-1:0] wdb,
                       input bit iss, input int isr, input int r0, input int r1);
    exp_t e;
    int   ras [NRD];
    bit   run;
    reset = rst; we_a = wea; wa_a = AW'(waa); wd_a = wda;
    we_b = web; wa_b = AW'(wab); wd_b = wdb; iss_v = iss; iss_rd = AW'(isr);
    ras[0] = r0; ras[1] = r1;
    ra = {AW'(r1), AW'(r0)};
    if (m_valid) begin
      run   = (m_init_left == 0);
      e.cyc = cyc;
      e.rdy = run;
      for (int p = 0; p < NRD; p++) begin
        e.rd[p] = '0;
        e.busy[p] = 1'b0;
        if (run && ras[p] != ZR) begin
          if (web && wab == ras[p])      e.rd[p] = wdb;
          else if (wea && waa == ras[p]) e.rd[p] = wda;
          else                           e.rd[p] = m_reg[ras[p]];
          e.busy[p] = m_pend[ras[p]] && !(web && wab == ras[p]);
        end
      end
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (rst) begin
      m_valid = 1;
      m_init_left = NREG;
      foreach (m_pend[k]) m_pend[k] = 0;
    end else if (m_valid && m_init_left > 0) begin
      m_reg[NREG - m_init_left] = init_v(NREG - m_init_left);
      m_init_left--;
    end else if (m_valid) begin
      if (wea && waa != ZR) m_reg[waa] = wda;
      if (web && wab != ZR) m_reg[wab] = wdb;
      if (web) m_pend[wab] = 0;
      if (iss && isr != ZR) m_pend[isr] = 1;
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int r0, input int r1);
    cycle(0, 0, 0, '0, 0, 0, '0, 0, 0, r0, r1);
  endtask

  // Monitor: outputs are combinational, so one expected entry per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      tests++;
      if (rdy !== e.rdy) begin
        fails++;
        $display("FAIL rdy cyc=%0d got=%b exp=%b", e.cyc, rdy, e.rdy);
      end
      for (int p = 0; p < NRD; p++) begin
        tests++;
        if (rd[p*N +: N] !== e.rd[p]) begin
          fails++;
          $display("FAIL rd%0d cyc=%0d got=%h exp=%h", p, e.cyc, rd[p*N +: N], e.rd[p]);
        end
        tests++;
        if (busy[p] !== e.busy[p]) begin
          fails++;
          $display("FAIL busy%0d cyc=%0d got=%b exp=%b", p, e.cyc, busy[p], e.busy[p]);
        end
      end
    end
  end

  function automatic int raddr();
    return ($urandom_range(0, 4) == 0) ? ZR : int'($urandom_range(0, 11));
  endfunction

  initial begin
    reset = 1; we_a = 0; we_b = 0; iss_v = 0;
    wa_a = '0; wa_b = '0; wd_a = '0; wd_b = '0; iss_rd = '0; ra = '0;
    // Init sequence
    cycle(1, 0, 0, '0, 0, 0, '0, 0, 0, 5, 31);
    for (int i = 0; i < NREG + 2; i++) idle(5, 31);
    // Forwarding priority, same cycle and next cycle
    cycle(0, 1, 3, 64'hAA, 1, 3, 64'hBB, 0, 0, 3, 3);
    idle(3, 4);
    // Zero register
    cycle(0, 1, 31, 64'hFF, 0, 0, '0, 1, 31, 31, 31);
    idle(31, 31);
    // Scoreboard set, resolve by we_b, then clear
    cycle(0, 0, 0, '0, 0, 0, '0, 1, 7, 7, 0);
    idle(7, 7);
    cycle(0, 0, 0, '0, 1, 7, 64'h1234, 0, 0, 7, 7);
    idle(7, 7);
    // Set/clear collision: set wins
    cycle(0, 0, 0, '0, 0, 0, '0, 1, 9, 9, 9);
    cycle(0, 0, 0, '0, 1, 9, 64'h99, 1, 9, 9, 9);
    idle(9, 9);
    // we_a does not resolve busy
    cycle(0, 1, 9, 64'h55, 0, 0, '0, 0, 0, 9, 9);
    cycle(0, 0, 0, '0, 1, 9, 64'h77, 0, 0, 9, 1);
    idle(9, 9);
    // Reset mid-run with pending reg and writes during init
    cycle(0, 1, 4, 64'hDEAD, 0, 0, '0, 1, 4, 4, 4);
    idle(4, 4);
    cycle(1, 0, 0, '0, 0, 0, '0, 0, 0, 4, 4);
    for (int i = 0; i < NREG; i++)
      cycle(0, 1, 4, 64'hBAD, 1, 6, 64'hBAD, 1, 4, 4, 6);
    idle(4, 6);
    idle(4, 6);
    // Randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 399) == 0),
            $urandom_range(0, 1), raddr(), {$urandom, $urandom},
            $urandom_range(0, 2) == 0, raddr(), {$urandom, $urandom},
            $urandom_range(0, 3) == 0, raddr(), raddr(), raddr());
    end
    idle(0, 0);
    @(negedge clk); @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
